// File: rtl/cabac_cu_luma_mode_sched.sv
// Intra luma mode scheduler for one CU in the CABAC front end.
// Latches the CU parameters on start_i and derives the left/top neighbour modes of each PU.
// For each PU it works out the MPM list and binarises the PU mode into two ctx pairs.
// The pairs go out in syntax order on a valid/ready port:
// first every prev_intra_luma_pred_flag pair, then every mpm_idx / rem_intra_luma_pred_mode
// pair.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           start one CU (sampled only while idle)
//   part_nxn_i        1: four PUs, 0: one PU
//   pu_mode_i         PU k luma mode at [6k+5:6k]
//   left_mode_i       left neighbour modes of PU0 / PU2, qualified by left_avail_i
//   top_mode_i        top neighbour modes of PU0 / PU1, qualified by top_avail_i
//   pair_o, valid_o   ctx pair towards the bin FIFO, accepted when ready_i is high
//   busy_o            CU in progress
//   done_o            one-cycle pulse after the last pair is accepted
module cabac_cu_luma_mode_sched #(
  parameter int unsigned MODE_W  = 6,
  parameter int unsigned PAIR_W  = 11,
  parameter int unsigned DC_MODE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  part_nxn_i,
  input  logic [4*MODE_W-1:0]   pu_mode_i,
  input  logic [2*MODE_W-1:0]   left_mode_i,
  input  logic [2*MODE_W-1:0]   top_mode_i,
  input  logic [1:0]            left_avail_i,
  input  logic [1:0]            top_avail_i,
  output logic [PAIR_W-1:0]     pair_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {StIdle, StFlag, StRem, StDrain} state_e;

  localparam logic [MODE_W-1:0] DcMode = MODE_W'(DC_MODE);

  state_e state_q, state_d;

  logic [4*MODE_W-1:0] mode_q, mode_d;
  logic [2*MODE_W-1:0] left_q, left_d, top_q, top_d;
  logic [1:0]          lav_q, lav_d, tav_q, tav_d;
  logic                nxn_q, nxn_d;
  logic [1:0]          pu_cnt_q, pu_cnt_d;
  logic [PAIR_W-1:0]   pair1_q [4];
  logic [PAIR_W-1:0]   pair1_d [4];
  logic [PAIR_W-1:0]   pair_q, pair_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;

  logic slot_free, last_pu;
  assign slot_free = !valid_q || ready_i;
  assign last_pu   = (pu_cnt_q == (nxn_q ? 2'd3 : 2'd0));

  // Neighbour selection for the PU being issued; intra-CU neighbours are always available.
  logic [MODE_W-1:0] cur_mode, cand_a, cand_b;
  always_comb begin
    cur_mode = mode_q[MODE_W-1:0];
    cand_a   = DcMode;
    cand_b   = DcMode;
    unique case (pu_cnt_q)
      2'd0: begin
        cur_mode = mode_q[MODE_W-1:0];
        cand_a   = lav_q[0] ? left_q[MODE_W-1:0] : DcMode;
        cand_b   = tav_q[0] ? top_q[MODE_W-1:0]  : DcMode;
      end
      2'd1: begin
        cur_mode = mode_q[2*MODE_W-1:MODE_W];
        cand_a   = mode_q[MODE_W-1:0];
        cand_b   = tav_q[1] ? top_q[2*MODE_W-1:MODE_W] : DcMode;
      end
      2'd2: begin
        cur_mode = mode_q[3*MODE_W-1:2*MODE_W];
        cand_a   = lav_q[1] ? left_q[2*MODE_W-1:MODE_W] : DcMode;
        cand_b   = mode_q[MODE_W-1:0];
      end
      2'd3: begin
        cur_mode = mode_q[4*MODE_W-1:3*MODE_W];
        cand_a   = mode_q[3*MODE_W-1:2*MODE_W];
        cand_b   = mode_q[2*MODE_W-1:MODE_W];
      end
      default: ;
    endcase
  end

  // Intra luma mode binariser: MPM list, prev flag, mpm_idx or 5-bit remainder.
  logic [MODE_W-1:0] mpm0, mpm1, mpm2;
  logic              hit0, hit1, hit2, pred_flag;
  logic [4:0]        rem_mode;
  logic [PAIR_W-1:0] pair0_cur, pair1_cur;
  always_comb begin
    mpm0 = cand_a;
    mpm1 = cand_b;
    mpm2 = MODE_W'(26);
    if (cand_a == cand_b) begin
      if (cand_a < MODE_W'(2)) begin
        mpm0 = MODE_W'(0);
        mpm1 = MODE_W'(1);
        mpm2 = MODE_W'(26);
      end else begin
        // Angular neighbours of A, wrapped modulo 32 over the angular range 2..33.
        mpm0 = cand_a;
        mpm1 = MODE_W'(5'(cand_a[4:0] + 5'd29)) + MODE_W'(2);
        mpm2 = MODE_W'(5'(cand_a[4:0] - 5'd1)) + MODE_W'(2);
      end
    end else if (cand_a != MODE_W'(0) && cand_b != MODE_W'(0)) begin
      mpm2 = MODE_W'(0);
    end else if (cand_a != MODE_W'(1) && cand_b != MODE_W'(1)) begin
      mpm2 = MODE_W'(1);
    end
    hit0      = (cur_mode == mpm0);
    hit1      = (cur_mode == mpm1);
    hit2      = (cur_mode == mpm2);
    pred_flag = hit0 || hit1 || hit2;
    // Remainder = mode minus the number of MPM entries below it; always fits in 5 bits.
    rem_mode  = cur_mode[4:0] - 5'(mpm0 < cur_mode) - 5'(mpm1 < cur_mode)
                - 5'(mpm2 < cur_mode);
    pair0_cur = PAIR_W'({2'b00, pred_flag, 3'd0, 5'd30});
    if (hit0) begin
      pair1_cur = PAIR_W'({2'b10, 1'b0, 3'd1, 5'd0});
    end else if (hit1) begin
      pair1_cur = PAIR_W'({2'b10, 1'b0, 3'd2, 5'd2});
    end else if (hit2) begin
      pair1_cur = PAIR_W'({2'b10, 1'b0, 3'd2, 5'd3});
    end else begin
      pair1_cur = PAIR_W'({2'b10, 1'b0, 3'd5, rem_mode});
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i)               state_d = StFlag;
      StFlag:  if (slot_free && last_pu)  state_d = StRem;
      StRem:   if (slot_free && last_pu)  state_d = StDrain;
      StDrain: if (valid_q && ready_i)    state_d = StIdle;
      default:                            state_d = StIdle;
    endcase
  end

  // Output logic.
  always_comb begin
    busy_o  = (state_q != StIdle);
    pair_o  = pair_q;
    valid_o = valid_q;
    done_o  = done_q;
  end

  // Datapath next-state.
  always_comb begin
    mode_d   = mode_q;
    left_d   = left_q;
    top_d    = top_q;
    lav_d    = lav_q;
    tav_d    = tav_q;
    nxn_d    = nxn_q;
    pu_cnt_d = pu_cnt_q;
    pair1_d  = pair1_q;
    pair_d   = pair_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mode_d   = pu_mode_i;
          left_d   = left_mode_i;
          top_d    = top_mode_i;
          lav_d    = left_avail_i;
          tav_d    = top_avail_i;
          nxn_d    = part_nxn_i;
          pu_cnt_d = 2'd0;
        end
      end
      StFlag: begin
        if (slot_free) begin
          pair_d            = pair0_cur;
          valid_d           = 1'b1;
          pair1_d[pu_cnt_q] = pair1_cur;
          pu_cnt_d          = last_pu ? 2'd0 : pu_cnt_q + 2'd1;
        end
      end
      StRem: begin
        if (slot_free) begin
          pair_d   = pair1_q[pu_cnt_q];
          valid_d  = 1'b1;
          pu_cnt_d = last_pu ? 2'd0 : pu_cnt_q + 2'd1;
        end
      end
      StDrain: begin
        if (valid_q && ready_i) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= '0;
      left_q   <= '0;
      top_q    <= '0;
      lav_q    <= '0;
      tav_q    <= '0;
      nxn_q    <= 1'b0;
      pu_cnt_q <= 2'd0;
      for (int i = 0; i < 4; i++) pair1_q[i] <= '0;
      pair_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      left_q   <= left_d;
      top_q    <= top_d;
      lav_q    <= lav_d;
      tav_q    <= tav_d;
      nxn_q    <= nxn_d;
      pu_cnt_q <= pu_cnt_d;
      pair1_q  <= pair1_d;
      pair_q   <= pair_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

endmodule
